// File: rtl/dm_sba_mem_if.sv
// Request/grant/response bus between the SBA master port and a word-memory responder.
// The master drives the request side; the slave drives the grant and the response.
interface dm_sba_mem_if;
    logic        slave_req;
    logic [31:0] slave_add;
    logic        slave_we;
    logic [31:0] slave_wdata;
    logic [3:0]  slave_be;
    logic        slave_gnt;
    logic        slave_r_valid;
    logic        slave_r_err;
    logic        slave_r_other_err;
    logic [31:0] slave_r_rdata;

    modport master (
        output slave_req, slave_add, slave_we, slave_wdata, slave_be,
        input  slave_gnt, slave_r_valid, slave_r_err, slave_r_other_err, slave_r_rdata
    );

    modport slave (
        input  slave_req, slave_add, slave_we, slave_wdata, slave_be,
        output slave_gnt, slave_r_valid, slave_r_err, slave_r_other_err, slave_r_rdata
    );
endinterface

// File: rtl/dm_sba_mem_slave.sv
// Single-outstanding word memory behind the SBA req/gnt/rvalid handshake, with programmable
// grant/response wait states, address-range checking and injectable bus errors.
module dm_sba_mem_slave #(
    parameter int unsigned MEM_WORDS = 32'd256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned GNT_WAIT  = 32'd0,
    parameter int unsigned RSP_LAT   = 32'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        err_inject_i,
    dm_sba_mem_if.slave bus
);
    localparam int unsigned AW       = (MEM_WORDS > 32'd1) ? $clog2(MEM_WORDS) : 32'd1;
    localparam logic [3:0]  GNT_INIT = 4'((GNT_WAIT > 32'd0) ? (GNT_WAIT - 32'd1) : 32'd0);
    localparam logic [3:0]  RSP_INIT = 4'((RSP_LAT > 32'd0) ? (RSP_LAT - 32'd1) : 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GWAIT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    cnt_r, cnt_s;
    logic          gnt_s, r_valid_s, accept_s;
    logic          err_r, other_err_r;
    logic [31:0]   rdata_r;
    logic [31:0]   off_word_s;
    logic          in_range_s, access_ok_s, wr_en_s, rd_en_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   mem_r [MEM_WORDS];

    // The subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign off_word_s  = (bus.slave_add - BASE_ADDR) >> 2;
    assign in_range_s  = (bus.slave_add >= BASE_ADDR) && (off_word_s < MEM_WORDS);
    assign idx_s       = off_word_s[AW-1:0];
    assign access_ok_s = !err_inject_i && in_range_s && (bus.slave_be != 4'b0000);
    assign accept_s    = gnt_s && !rst_i;
    assign wr_en_s     = accept_s && access_ok_s && bus.slave_we;
    assign rd_en_s     = accept_s && access_ok_s && !bus.slave_we;

    // Next-state, wait counters and handshake strobes.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        gnt_s     = 1'b0;
        r_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.slave_req && (GNT_WAIT == 32'd0)) begin
                    gnt_s   = 1'b1;
                    state_s = ST_RESP;
                    cnt_s   = RSP_INIT;
                end else if (bus.slave_req) begin
                    state_s = ST_GWAIT;
                    cnt_s   = GNT_INIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GWAIT: begin
                if (!bus.slave_req) begin
                    state_s = ST_IDLE;
                end else if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    gnt_s   = 1'b1;
                    state_s = ST_RESP;
                    cnt_s   = RSP_INIT;
                end
            end
            ST_RESP: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    r_valid_s = 1'b1;
                    state_s   = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and the response captured at accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            err_r       <= 1'b0;
            other_err_r <= 1'b0;
            rdata_r     <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                err_r       <= err_inject_i || !in_range_s;
                other_err_r <= !err_inject_i && in_range_s && (bus.slave_be == 4'b0000);
                rdata_r     <= rd_en_s ? mem_r[idx_s] : 32'd0;
            end
        end
    end

    // Byte-lane writes; storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && bus.slave_be[i]) begin
                mem_r[idx_s][8*i +: 8] <= bus.slave_wdata[8*i +: 8];
            end
        end
    end

    assign bus.slave_gnt         = accept_s;
    assign bus.slave_r_valid     = r_valid_s && !rst_i;
    assign bus.slave_r_err       = bus.slave_r_valid && err_r;
    assign bus.slave_r_other_err = bus.slave_r_valid && other_err_r;
    assign bus.slave_r_rdata     = bus.slave_r_valid ? rdata_r : 32'd0;
endmodule
